// File: rtl/speaker_serializer.sv
// Stereo I2S-style output stage for a CS4344-class DAC: derives MCLK/SCK/LRCK
// from a 512-cycle frame counter and shifts out 16+16 bit left-justified samples.
module speaker_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  input  logic        mute,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic        audio_sdin,
  output logic        sample_req
);

  logic [8:0]  r_cnt;
  logic [31:0] r_sr;
  logic        r_sample_req;

  logic        w_frame_end;
  logic        w_bit_end;

  assign w_frame_end = (r_cnt == 9'd511);
  assign w_bit_end   = (r_cnt[3:0] == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 9'd0;
    end else begin
      r_cnt <= r_cnt + 9'd1;
    end
  end

  // Handshake: sample_req is a one-cycle strobe with no backpressure; the
  // audio_l/audio_r/mute values present in that cycle are the ones captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_req <= 1'b0;
    end else begin
      r_sample_req <= (r_cnt == 9'd510);
    end
  end

  // Capture wins over shift on the last cycle of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 32'd0;
    end else if (w_frame_end) begin
      r_sr <= mute ? 32'd0 : {audio_l, audio_r};
    end else if (w_bit_end) begin
      r_sr <= {r_sr[30:0], 1'b0};
    end
  end

  assign audio_mclk = r_cnt[1];
  assign audio_sck  = r_cnt[3];
  assign audio_lrck = r_cnt[8];
  assign audio_sdin = r_sr[31];
  assign sample_req = r_sample_req;

endmodule

// File: tb/tb_speaker_serializer.sv
// Directed bench for speaker_serializer: reset, clock ratios, serial pattern,
// capture window, mute and mid-frame reset against hand-computed frames.
module tb_speaker_serializer;

  logic        clk;
  logic        rst_n;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        mute;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;
  logic        sample_req;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [8:0]  m_cnt;

  speaker_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .mute       (mute),
    .audio_mclk (audio_mclk),
    .audio_sck  (audio_sck),
    .audio_lrck (audio_lrck),
    .audio_sdin (audio_sdin),
    .sample_req (sample_req)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame position as the bench expects it to be
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 9'd0;
    else        m_cnt <= m_cnt + 9'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cnt(input logic [8:0] t);
    int budget = 0;
    while (m_cnt != t && budget < 1100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 1100) check_val("wait_timeout", 32'(budget), 32'(0));
  endtask

  function automatic logic [31:0] outs5();
    return {27'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req};
  endfunction

  // Reads the frame starting at the next cnt=0; caller sits at cnt 511 or 0.
  task automatic read_frame(input string tag);
    logic [31:0] f;
    logic [31:0] exp;
    logic        b0;
    int          unstable = 0;
    int          lr_bad = 0;
    f = 32'd0;
    for (int k = 0; k < 32; k++) begin
      wait_cnt(9'(k * 16));
      b0 = audio_sdin;
      wait_cnt(9'(k * 16 + 8));
      f[31 - k] = audio_sdin;
      if (audio_sdin !== b0) unstable++;
      if (audio_lrck !== (k >= 16)) lr_bad++;
      wait_cnt(9'(k * 16 + 15));
      if (audio_sdin !== b0) unstable++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_val({tag, "_data"}, f, exp);
    check_val({tag, "_stable"}, 32'(unstable), 32'(0));
    check_val({tag, "_lrck"}, 32'(lr_bad), 32'(0));
  endtask

  // From reset release: first sample_req after 511 cycles, all-zero data.
  task automatic first_frame(input string tag);
    int   n = 0;
    logic acc = 1'b0;
    while (!sample_req && n < 600) begin
      @(negedge clk);
      n++;
      acc = acc | audio_sdin;
    end
    check_val({tag, "_req_delay"}, 32'(n), 32'(511));
    check_val({tag, "_zero_frame"}, {31'd0, acc}, 32'd0);
  endtask

  task automatic clock_ratios();
    logic [2:0] cur, prv;
    int per[3] = '{4, 16, 512};
    int rises[3], highs[3], last[3], bad_per[3];
    int bad_align = 0;
    for (int s = 0; s < 3; s++) begin
      rises[s] = 0; highs[s] = 0; last[s] = -1; bad_per[s] = 0;
    end
    prv = {audio_mclk, audio_sck, audio_lrck};
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      cur = {audio_mclk, audio_sck, audio_lrck};
      for (int s = 0; s < 3; s++) begin
        if (cur[2 - s]) highs[s]++;
        if (cur[2 - s] && !prv[2 - s]) begin
          rises[s]++;
          if (last[s] >= 0 && (i - last[s]) != per[s]) bad_per[s]++;
          last[s] = i;
        end
      end
      if (cur[0] != prv[0] && !(prv[1] && !cur[1])) bad_align++;
      prv = cur;
    end
    check_val("mclk_rises", 32'(rises[0]), 32'(512));
    check_val("mclk_high", 32'(highs[0]), 32'(1024));
    check_val("mclk_period", 32'(bad_per[0]), 32'(0));
    check_val("sck_rises", 32'(rises[1]), 32'(128));
    check_val("sck_high", 32'(highs[1]), 32'(1024));
    check_val("sck_period", 32'(bad_per[1]), 32'(0));
    check_val("lrck_rises", 32'(rises[2]), 32'(4));
    check_val("lrck_high", 32'(highs[2]), 32'(1024));
    check_val("lrck_period", 32'(bad_per[2]), 32'(0));
    check_val("lrck_sck_align", 32'(bad_align), 32'(0));
  endtask

  initial begin
    rst_n   = 1'b0;
    audio_l = 16'hA5C3;
    audio_r = 16'h5FFF;
    mute    = 1'b0;

    // reset held 5 cycles, outputs low throughout
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("reset_outs", outs5(), 32'd0);
    end
    rst_n = 1'b1;
    first_frame("boot");

    // pattern frame
    exp_q.push_back(32'hA5C3_5FFF);
    read_frame("pattern");

    clock_ratios();

    // capture window: change one cycle after sample_req
    wait_cnt(9'd100);
    audio_l = 16'h0000;
    audio_r = 16'h1234;
    wait_cnt(9'd511);
    wait_cnt(9'd0);
    audio_l = 16'hFFFF;
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'hFFFF_1234);
    read_frame("late_change");
    read_frame("late_next");

    // change in the cycle before sample_req is used
    wait_cnt(9'd510);
    audio_l = 16'h0F0F;
    wait_cnt(9'd511);
    check_val("req_at_511", {31'd0, sample_req}, 32'd1);
    exp_q.push_back(32'h0F0F_1234);
    read_frame("early_change");

    // mute at capture, released mid-frame
    wait_cnt(9'd400);
    audio_l = 16'hB000;
    audio_r = 16'hB000;
    mute    = 1'b1;
    wait_cnt(9'd511);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'hB000_B000);
    fork
      read_frame("muted");
      begin
        wait_cnt(9'd200);
        mute = 1'b0;
      end
    join
    read_frame("unmuted");

    // reset mid-frame: bit 18 is right-sample bit 2 of 0xB000 -> 1
    wait_cnt(9'd300);
    check_val("pre_reset_outs", outs5(), 32'b01110);
    #1 rst_n = 1'b0;
    #1 check_val("async_reset_outs", outs5(), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("midreset_outs", outs5(), 32'd0);
    end
    rst_n = 1'b1;
    first_frame("rerun");
    exp_q.push_back(32'hB000_B000);
    read_frame("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
